// File: rtl/mod_seq_ctrl_pkg.sv
// mod_seq_pkg: modulation and FSM encodings shared by the PN sequencer.
package mod_seq_pkg;
    typedef enum logic [1:0] {MODE_CW = 2'b00, MODE_ASK = 2'b01, MODE_FSK = 2'b10, MODE_BPSK = 2'b11} mode_e;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;
endpackage

// File: rtl/mod_seq_ctrl_if.sv
// mod_seq_ctrl_if: control-register, generator and DDS signals of the sequencer.
// n_frames exists only when FRAME_CNT_EN is defined.
interface mod_seq_ctrl_if
    import mod_seq_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int FW_W  = 32,
    parameter int PW_W  = 12
);
    logic start, stop, bit_in, lfsr_load, lfsr_en, amp_en, busy, frame_done;
    mode_e mode;
    logic [DIV_W-1:0] baud_div;
    logic [FW_W-1:0] fw_mark, fw_space, freq_word;
    logic [PW_W-1:0] phase_off;
`ifdef FRAME_CNT_EN
    logic [7:0] n_frames;
`endif
    modport master (
`ifdef FRAME_CNT_EN
        output n_frames,
`endif
        output start, stop, mode, baud_div, fw_mark, fw_space, bit_in,
        input  lfsr_load, lfsr_en, freq_word, phase_off, amp_en, busy, frame_done
    );
    modport slave (
`ifdef FRAME_CNT_EN
        input  n_frames,
`endif
        input  start, stop, mode, baud_div, fw_mark, fw_space, bit_in,
        output lfsr_load, lfsr_en, freq_word, phase_off, amp_en, busy, frame_done
    );
endinterface

// File: rtl/mod_seq_ctrl_baud_tick_gen.sv
// baud_tick_gen: counts 0..div_i while enabled and ticks on the terminal count.
module baud_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);
    logic [DIV_W-1:0] cnt_q;
    assign tick_o = en_i && cnt_q == div_i;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= tick_o ? '0 : cnt_q + DIV_W'(1);
endmodule

// File: rtl/mod_seq_ctrl.sv
// mod_seq_ctrl: paces the m-sequence generator and maps each PN bit onto DDS controls.
// Defining FRAME_CNT_EN adds an n_frames count that ends the run automatically.
module mod_seq_ctrl
    import mod_seq_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int PERIOD = 7,
    parameter int FW_W   = 32,
    parameter int PW_W   = 12
) (
    input logic clk,
    input logic reset_n,
    mod_seq_ctrl_if.slave bus
);
    localparam int IDX_W = PERIOD > 1 ? $clog2(PERIOD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PERIOD - 1);
    localparam logic [PW_W-1:0] PHASE_PI = {1'b1, {(PW_W-1){1'b0}}};
    state_e state_q, state_d;
    mode_e mode_q;
    logic [DIV_W-1:0] div_q;
    logic [FW_W-1:0] fw_mark_q, fw_space_q, freq_q;
    logic [PW_W-1:0] phase_q;
    logic [IDX_W-1:0] idx_q;
    logic amp_q, stop_q, en_d1_q, tick, accept, frame_end, auto_stop;
    assign accept         = state_q == IDLE && bus.start && !bus.stop;
    assign bus.lfsr_load  = state_q == LOAD;
    assign bus.busy       = state_q != IDLE;
    assign bus.lfsr_en    = tick && state_q == RUN;
    assign frame_end      = bus.lfsr_en && idx_q == LAST_IDX;
    assign bus.frame_done = frame_end;
    assign bus.freq_word  = freq_q;
    assign bus.phase_off  = phase_q;
    assign bus.amp_en     = amp_q;
    baud_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clr_i  (state_q == LOAD),
        .en_i   (state_q == RUN || state_q == DRAIN),
        .div_i  (div_q),
        .tick_o (tick)
    );
`ifdef FRAME_CNT_EN
    logic [7:0] n_frames_q, frames_q;
    assign auto_stop = frame_end && n_frames_q != 8'd0 && frames_q + 8'd1 == n_frames_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            n_frames_q <= '0;
            frames_q   <= '0;
        end else if (accept) begin
            n_frames_q <= bus.n_frames;
            frames_q   <= '0;
        end else if (frame_end) frames_q <= frames_q + 8'd1;
`else
    assign auto_stop = 1'b0;
`endif
    // A stop seen during LOAD is held and takes effect at the first RUN tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? LOAD : IDLE;
            LOAD:    state_d = RUN;
            RUN:     state_d = (bus.stop || (stop_q && tick) || auto_stop) ? DRAIN : RUN;
            DRAIN:   state_d = tick ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_CW;
            div_q      <= '0;
            fw_mark_q  <= '0;
            fw_space_q <= '0;
            idx_q      <= '0;
            stop_q     <= 1'b0;
            en_d1_q    <= 1'b0;
            freq_q     <= '0;
            phase_q    <= '0;
            amp_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            en_d1_q <= bus.lfsr_en;
            if (accept) begin
                mode_q     <= bus.mode;
                div_q      <= bus.baud_div;
                fw_mark_q  <= bus.fw_mark;
                fw_space_q <= bus.fw_space;
                idx_q      <= '0;
                stop_q     <= 1'b0;
            end else begin
                if (state_q == LOAD && bus.stop) stop_q <= 1'b1;
                if (bus.lfsr_en) idx_q <= frame_end ? '0 : idx_q + IDX_W'(1);
            end
            // bit_in is valid the cycle after lfsr_en, so the DDS controls land two cycles after the tick.
            if (state_d == IDLE) begin
                freq_q  <= '0;
                phase_q <= '0;
                amp_q   <= 1'b0;
            end else if (en_d1_q) begin
                freq_q  <= (mode_q == MODE_FSK && !bus.bit_in) ? fw_space_q : fw_mark_q;
                phase_q <= (mode_q == MODE_BPSK && !bus.bit_in) ? PHASE_PI : '0;
                amp_q   <= mode_q != MODE_ASK || bus.bit_in;
            end
        end
endmodule

// File: tb/tb_mod_seq_ctrl.sv
// tb_mod_seq_ctrl: randomized bench checking mod_seq_ctrl against a bit-period timing model.
module tb_mod_seq_ctrl;
    import mod_seq_pkg::*;
    localparam int PERIOD = 7;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic bits [0:255];
    mod_seq_ctrl_if #(.DIV_W(16), .FW_W(32), .PW_W(12)) bus ();
    mod_seq_ctrl #(.DIV_W(16), .PERIOD(PERIOD), .FW_W(32), .PW_W(12)) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    task automatic fill_bits();
        for (int i = 0; i < 256; i++) bits[i] = 1'($urandom);
    endtask
    // Expected timing: start in cycle 0, LOAD in cycle 1, tick k at 1+k*(div+1);
    // the generator answers each lfsr_en with its next bit, which shows on the DDS side two cycles on.
    task automatic drive_run(input string nm, input mode_e m, input int d, input logic [31:0] fm,
                             input logic [31:0] fs, input int s, input int f);
        int per, seff, tend, kmax, gen, j, k;
        logic [3:0] exp_c, got_c;
        logic [44:0] exp_d, got_d;
        logic b;
        per  = d + 1;
        seff = (s < 0) ? 1 << 20 : s;
        if (s == 1) seff = 1 + per;
        if (f > 0 && 1 + PERIOD * f * per < seff) seff = 1 + PERIOD * f * per;
        tend = 1 + ((seff - 1) / per + 1) * per;
        kmax = (seff - 1) / per;
        gen  = 0;
        for (int c = 0; c <= tend + 2; c++) begin
            bus.start = (c == 0) || (c >= 2 && c <= tend && $urandom_range(0, 7) == 0);
            bus.stop  = (c == s);
            if (c == 0) begin
                bus.mode     = m;
                bus.baud_div = d[15:0];
                bus.fw_mark  = fm;
                bus.fw_space = fs;
`ifdef FRAME_CNT_EN
                bus.n_frames = f[7:0];
`endif
            end else begin
                bus.mode     = mode_e'($urandom_range(0, 3));
                bus.baud_div = 16'($urandom_range(0, 9));
                bus.fw_mark  = $urandom;
                bus.fw_space = $urandom;
`ifdef FRAME_CNT_EN
                bus.n_frames = 8'($urandom_range(1, 3));
`endif
            end
            bus.bit_in = bits[gen];
            @(negedge clk);
            k = (c >= 1 + per && (c - 1) % per == 0) ? (c - 1) / per : 0;
            exp_c = {c == 1, k > 0 && c <= seff, c >= 1 && c <= tend, k > 0 && c <= seff && k % PERIOD == 0};
            got_c = {bus.lfsr_load, bus.lfsr_en, bus.busy, bus.frame_done};
            checks++;
            if (got_c !== exp_c) begin
                failures++;
                $display("FAIL %s ctrl cycle %0d: load/en/busy/frame_done got %b expected %b", nm, c, got_c, exp_c);
            end
            j = (c >= 3) ? (c - 3) / per : 0;
            if (j > kmax) j = kmax;
            b = bits[j];
            exp_d = (c > tend || j < 1) ? '0 :
                    {(m == MODE_FSK && !b) ? fs : fm, (m == MODE_BPSK && !b) ? 12'h800 : 12'h000, m != MODE_ASK || b};
            got_d = {bus.freq_word, bus.phase_off, bus.amp_en};
            checks++;
            if (got_d !== exp_d) begin
                failures++;
                $display("FAIL %s dds cycle %0d: freq/phase/amp got %h expected %h", nm, c, got_d, exp_d);
            end
            if (bus.lfsr_en === 1'b1 && gen < 255) gen++;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask
    task automatic test_reset();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.bit_in = 1'b0;
        bus.mode = MODE_CW;
        bus.baud_div = '0;
        bus.fw_mark = '0;
        bus.fw_space = '0;
`ifdef FRAME_CNT_EN
        bus.n_frames = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.lfsr_load, bus.lfsr_en, bus.busy, bus.frame_done, bus.freq_word, bus.phase_off, bus.amp_en} !== '0) begin
            failures++;
            $display("FAIL reset outputs: got busy=%b freq=%h phase=%h amp=%b expected all 0",
                     bus.busy, bus.freq_word, bus.phase_off, bus.amp_en);
        end
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.lfsr_load} !== 2'b00) begin
            failures++;
            $display("FAIL reset idle: busy/load got %b expected 00", {bus.busy, bus.lfsr_load});
        end
        @(posedge clk);
        #1;
    endtask
    task automatic test_cw_pacing();
        fill_bits();
        drive_run("cw_pacing", MODE_CW, 3, 32'h1234_5678, 32'h0, 62, 0);
    endtask
    task automatic test_fsk();
        fill_bits();
        bits[1] = 1'b1;
        bits[2] = 1'b0;
        bits[3] = 1'b1;
        drive_run("fsk", MODE_FSK, 2, 32'h1000, 32'h0800, 12, 0);
    endtask
    task automatic test_bpsk();
        fill_bits();
        bits[1] = 1'b0;
        bits[2] = 1'b1;
        drive_run("bpsk", MODE_BPSK, 1, $urandom, $urandom, 20, 0);
    endtask
    task automatic test_ask();
        logic [6:0] pat;
        fill_bits();
        pat = 7'b1110100;
        for (int i = 0; i < 7; i++) bits[i + 1] = pat[6 - i];
        drive_run("ask_stop_mid_bit", MODE_ASK, 2, $urandom, $urandom, 23, 0);
    endtask
    task automatic test_div0();
        fill_bits();
        drive_run("div0", mode_e'($urandom_range(0, 3)), 0, $urandom, $urandom, 15, 0);
    endtask
    task automatic test_stop_edges();
        fill_bits();
        drive_run("stop_in_load", MODE_FSK, 3, $urandom, $urandom, 1, 0);
        fill_bits();
        drive_run("stop_at_run_entry", MODE_ASK, 2, $urandom, $urandom, 2, 0);
    endtask
    task automatic test_start_stop();
        bus.start = 1'b1;
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.lfsr_load} !== 2'b00) begin
                failures++;
                $display("FAIL start_stop cycle %0d: busy/load got %b expected 00", i, {bus.busy, bus.lfsr_load});
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_back_to_back();
        fill_bits();
        drive_run("b2b_a", MODE_BPSK, 2, $urandom, $urandom, 17, 0);
        fill_bits();
        drive_run("b2b_b", MODE_ASK, 1, $urandom, $urandom, 9, 0);
    endtask
    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            fill_bits();
            drive_run("random", mode_e'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom, $urandom,
                      $urandom_range(2, 45), 0);
        end
    endtask
`ifdef FRAME_CNT_EN
    task automatic test_frames();
        fill_bits();
        drive_run("frames2", MODE_CW, 1, $urandom, $urandom, -1, 2);
        fill_bits();
        drive_run("frames1_stop_late", MODE_FSK, 0, $urandom, $urandom, 30, 1);
    endtask
`endif
    task automatic test_reset_mid_run();
        logic [31:0] fm;
        fm = $urandom | 32'h1;
        bus.start = 1'b1;
        bus.mode = MODE_CW;
        bus.baud_div = 16'd2;
        bus.fw_mark = fm;
        bus.bit_in = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.freq_word} !== {1'b1, fm}) begin
            failures++;
            $display("FAIL mid_run precondition: busy/freq got %b/%h expected 1/%h", bus.busy, bus.freq_word, fm);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.lfsr_load, bus.lfsr_en, bus.busy, bus.frame_done, bus.freq_word, bus.phase_off, bus.amp_en} !== '0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b freq=%h amp=%b expected all 0", bus.busy, bus.freq_word, bus.amp_en);
        end
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.freq_word} !== '0) begin
            failures++;
            $display("FAIL after_reset: busy/freq got %b/%h expected 0/0", bus.busy, bus.freq_word);
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        test_reset();
        test_cw_pacing();
        test_fsk();
        test_bpsk();
        test_ask();
        test_div0();
        test_stop_edges();
        test_start_stop();
        test_back_to_back();
        test_random();
`ifdef FRAME_CNT_EN
        test_frames();
`endif
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
